// File: rtl/spart_rx_deser.sv
// spart_rx_deser: 8N1 UART receive deserializer feeding the RX queue, with framing-error and overrun flags
module spart_rx_deser #(
    parameter int DIV_W   = 13,
    parameter int DATA_W  = 8,
    parameter int MIN_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              RX,
    input  logic              q_full,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_wr,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t state, state_n;
    logic rx_m, rxs, rxs_q;
    logic [DIV_W-1:0] div_l, div_n, div_sel, cnt, cnt_n;
    logic [3:0] idx, idx_n;
    logic [DATA_W-1:0] sh, sh_n, data_n;
    logic wr_n, fe_n, ov_n, samp;
    assign div_sel = baud_div < DIV_W'(MIN_DIV) ? DIV_W'(MIN_DIV) : baud_div;
    assign samp    = cnt == '0;
    assign busy    = state != IDLE;
    // next-state, bit timer, shift register and strobe decisions
    always_comb begin
        state_n = state;
        cnt_n   = samp ? div_l - DIV_W'(1) : cnt - DIV_W'(1);
        div_n   = div_l;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = rx_data;
        wr_n    = 1'b0;
        fe_n    = 1'b0;
        ov_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rxs_q && !rxs) begin
                    state_n = START;
                    div_n   = div_sel;
                    cnt_n   = (div_sel >> 1) - DIV_W'(1);
                end
            end
            START: if (samp) begin
                state_n = rxs ? IDLE : DATA;
                idx_n   = '0;
            end
            DATA: if (samp) begin
                sh_n  = {rxs, sh[DATA_W-1:1]};
                idx_n = idx + 4'd1;
                if (idx == 4'(DATA_W - 1)) state_n = STOP;
            end
            STOP: if (samp) begin
                if (rxs) begin
                    data_n  = sh;
                    wr_n    = !q_full;
                    ov_n    = q_full;
                    state_n = IDLE;
                end else begin
                    fe_n    = 1'b1;
                    state_n = BRK;
                end
            end
            BRK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // synchronizer, state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rxs       <= 1'b1;
            rxs_q     <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            div_l     <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_wr     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m      <= RX;
            rxs       <= rx_m;
            rxs_q     <= rxs;
            state     <= state_n;
            cnt       <= cnt_n;
            div_l     <= div_n;
            idx       <= idx_n;
            sh        <= sh_n;
            rx_data   <= data_n;
            rx_wr     <= wr_n;
            frame_err <= fe_n;
            overrun   <= ov_n;
        end
    end
endmodule

// File: tb/tb_spart_rx_deser.sv
// tb_spart_rx_deser: directed frames against a per-cycle event model of the receive deserializer
module tb_spart_rx_deser;
    logic clk = 1'b0;
    logic rst, RX, q_full;
    logic [12:0] baud_div;
    logic [7:0] rx_data;
    logic rx_wr, frame_err, overrun, busy;
    typedef struct {
        longint     at;
        int         kind;
        logic [7:0] data;
    } ev_t;
    ev_t evq[$];
    longint cyc = 0;
    int n_cmp = 0, n_bad = 0, wr_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    longint last_wr = -1, last_fe = -1, last_ov = -1;
    logic [7:0] exp_data = 8'h00;

    spart_rx_deser dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .RX(RX), .q_full(q_full),
        .rx_data(rx_data), .rx_wr(rx_wr), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // strobes become visible at the event's cycle; rst clears everything
    task automatic cmp_cycle();
        logic ew, ef, eo;
        ew = 1'b0;
        ef = 1'b0;
        eo = 1'b0;
        if (rst) begin
            evq.delete();
            exp_data = 8'h00;
        end else if (evq.size() > 0 && evq[0].at == cyc) begin
            ew = evq[0].kind == 0;
            ef = evq[0].kind == 1;
            eo = evq[0].kind == 2;
            if (evq[0].kind != 1) exp_data = evq[0].data;
            evq.delete(0);
        end
        if (rx_wr) begin wr_cnt++; last_wr = cyc; end
        if (frame_err) begin fe_cnt++; last_fe = cyc; end
        if (overrun) begin ov_cnt++; last_ov = cyc; end
        chk("outputs{wr,fe,ov,data}", {53'd0, rx_wr, frame_err, overrun, rx_data}, {53'd0, ew, ef, eo, exp_data});
    endtask

    task automatic wait_cyc(input longint n);
        repeat (n) begin
            @(negedge clk);
            cmp_cycle();
            #1;
        end
    endtask

    // frame whose falling edge is driven at cycle c reaches the queue at c + 2 (sync) + 1 + bit/2 + 9 bits
    task automatic send(input logic [7:0] b, input bit stop_ok, input int abort_at,
                        input int chg_at, input logic [12:0] new_div, output longint c);
        int dl;
        dl = baud_div < 13'd16 ? 16 : int'(baud_div);
        c = cyc;
        RX = 1'b0;
        if (abort_at < 0)
            evq.push_back('{at: c + 3 + dl / 2 + 9 * dl, kind: stop_ok ? (q_full ? 2 : 0) : 1, data: b});
        wait_cyc(dl);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            if (i == chg_at) baud_div = new_div;
            if (i == abort_at) begin
                wait_cyc(dl / 2);
                rst = 1'b1;
                wait_cyc(4);
                rst = 1'b0;
                wait_cyc(dl - dl / 2 - 4);
            end else wait_cyc(dl);
        end
        RX = stop_ok;
        wait_cyc(stop_ok ? dl : 3 * dl);
        RX = 1'b1;
    endtask

    initial begin
        longint c;
        int w0, f0, o0;
        rst = 1'b1;
        RX = 1'b1;
        q_full = 1'b0;
        baud_div = 13'd2604;
        #1;
        wait_cyc(3);
        chk("reset busy", busy, 0);
        chk("reset rx_data", rx_data, 0);
        rst = 1'b0;
        wait_cyc(5);
        // single 0xA5 at 19200
        w0 = wr_cnt;
        send(8'hA5, 1, -1, -1, 13'd0, c);
        wait_cyc(20);
        chk("t1 wr count", 64'(wr_cnt - w0), 1);
        chk("t1 wr time", 64'(last_wr - c), 24741);
        chk("t1 rx_data", rx_data, 8'hA5);
        // back-to-back frames, zero idle
        baud_div = 13'd434;
        w0 = wr_cnt;
        send(8'h00, 1, -1, -1, 13'd0, c);
        send(8'hFF, 1, -1, -1, 13'd0, c);
        send(8'h3C, 1, -1, -1, 13'd0, c);
        wait_cyc(20);
        chk("t2 wr count", 64'(wr_cnt - w0), 3);
        chk("t2 last wr time", 64'(last_wr - c), 4126);
        chk("t2 rx_data", rx_data, 8'h3C);
        // false start: 500 low cycles, far short of the half-bit sample point
        baud_div = 13'd2604;
        c = cyc;
        w0 = wr_cnt;
        f0 = fe_cnt;
        RX = 1'b0;
        wait_cyc(500);
        RX = 1'b1;
        wait_cyc(c + 1304 - cyc);
        chk("t3 busy before start sample", busy, 1);
        wait_cyc(1);
        chk("t3 busy after false start", busy, 0);
        wait_cyc(20);
        chk("t3 no strobes", 64'(wr_cnt - w0 + fe_cnt - f0), 0);
        // overrun with a divisor below the clamp
        baud_div = 13'd5;
        q_full = 1'b1;
        w0 = wr_cnt;
        o0 = ov_cnt;
        send(8'h81, 1, -1, -1, 13'd0, c);
        wait_cyc(10);
        chk("t5 overrun count", 64'(ov_cnt - o0), 1);
        chk("t5 overrun time", 64'(last_ov - c), 155);
        chk("t5 no wr", 64'(wr_cnt - w0), 0);
        chk("t5 rx_data", rx_data, 8'h81);
        q_full = 1'b0;
        send(8'h7E, 1, -1, -1, 13'd0, c);
        wait_cyc(10);
        chk("t5 wr after release", 64'(wr_cnt - w0), 1);
        chk("t5 rx_data 2", rx_data, 8'h7E);
        // framing error with odd divisor, stop low for three bit times
        baud_div = 13'd21;
        w0 = wr_cnt;
        f0 = fe_cnt;
        send(8'h3C, 0, -1, -1, 13'd0, c);
        wait_cyc(10);
        chk("t4 fe count", 64'(fe_cnt - f0), 1);
        chk("t4 fe time", 64'(last_fe - c), 202);
        chk("t4 no wr", 64'(wr_cnt - w0), 0);
        chk("t4 rx_data kept", rx_data, 8'h7E);
        send(8'h5A, 1, -1, -1, 13'd0, c);
        wait_cyc(10);
        chk("t4 rx_data recover", rx_data, 8'h5A);
        // reset during data bit 4, then a divisor change mid-frame
        baud_div = 13'd434;
        w0 = wr_cnt;
        send(8'hF0, 1, 4, -1, 13'd0, c);
        wait_cyc(10);
        chk("t6 aborted no wr", 64'(wr_cnt - w0), 0);
        chk("t6 rx_data after rst", rx_data, 8'h00);
        baud_div = 13'd2604;
        send(8'hC3, 1, -1, 3, 13'd434, c);
        wait_cyc(10);
        chk("t6 in-flight rx_data", rx_data, 8'hC3);
        chk("t6 in-flight wr time", 64'(last_wr - c), 24741);
        send(8'h69, 1, -1, -1, 13'd0, c);
        wait_cyc(10);
        chk("t6 next rx_data", rx_data, 8'h69);
        chk("t6 next wr time", 64'(last_wr - c), 4126);
        chk("t6 wr count", 64'(wr_cnt - w0), 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spart_rx_deser.md
Name: spart_rx_deser

Overview:
Receive deserializer of the SPART. Sits between the RX pin and the 8-entry RX queue, and converts 8N1 UART frames into bytes at the rate set by the DB (baud divisor) register. It also pushes completed bytes into the RX queue and flags framing errors and overruns to the status logic.

Parameters:
DIV_W, 13, width of baud divisor (DB register bits [12:0])
DATA_W, 8, data bits per frame
MIN_DIV, 16, smallest divisor honoured; smaller values are clamped to this

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous active-high reset
baud_div  input  DIV_W  clk cycles per bit, from DB register
RX  input  1  asynchronous UART line, idle high
q_full  input  1  RX queue full
rx_data  output  DATA_W  last received byte, LSB-first assembled
rx_wr  output  1  one-cycle push strobe into RX queue
frame_err  output  1  one-cycle pulse, stop bit sampled low
overrun  output  1  one-cycle pulse, good byte dropped because q_full
busy  output  1  high while not in IDLE

Behaviour:
- Reset values: all outputs 0; both RX sync flops 1; state IDLE; counters 0.
- RX passes through a 2-flop synchronizer (rxs). Start detect happens on the cycle rxs transitions 1->0 while in IDLE; that cycle is T0.
- Divisor handling:
  - At T0, latch div_l = max(baud_div, MIN_DIV).
  - baud_div changes mid-frame have no effect until the next T0.
- Bit timer: a down-counter. "Sample" means the cycle the counter reaches 0; the counter then reloads div_l-1.
- States:
  - IDLE: on start detect, load counter with (div_l>>1)-1 and go to START.
  - START: at sample, if rxs=1 it was a false start; go to IDLE with no outputs. If rxs=0, go to DATA with bit index 0.
  - DATA: at each sample, shift rxs into bit [index] (LSB first) and increment index. After bit DATA_W-1, go to STOP.
  - STOP, at sample, with rxs=1:
    - If q_full=0: rx_data <= shifted byte; rx_wr=1 the next cycle.
    - If q_full=1: rx_data is still updated; overrun=1 the next cycle; rx_wr stays 0.
    - Go to IDLE.
  - STOP, at sample, with rxs=0: frame_err=1 the next cycle; rx_data is unchanged; no rx_wr; go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. No start detect while in BREAK.
- Sample timing, relative to T0:
  - Start bit sampled at T0+div_l/2 (integer).
  - Data bit i sampled at T0+div_l/2+(i+1)*div_l.
  - Stop bit sampled at T0+div_l/2+9*div_l.
  - Strobes occur 1 cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered the cycle after the stop sample. A falling edge of the next start bit is detected even with no idle gap, because rxs is already 1 mid-stop-bit.
- rx_wr, frame_err and overrun are mutually exclusive and each lasts exactly 1 cycle.
- rst asserted mid-frame: return to IDLE next clk, all outputs 0, partial byte discarded. The bench must see no strobe from the aborted frame.
- busy=1 in START/DATA/STOP/BREAK.
- Counter and index widths: counter is DIV_W bits; index is 4 bits; no wrap is possible because div_l ≥ MIN_DIV.

Test Plan:
1. baud_div=2604 (19200), send 0xA5 8N1 -> exactly one rx_wr, rx_data=0xA5, rx_wr lands at T0+1302+9*2604+1 ±2 cycles (sync), frame_err=overrun=0.
2. baud_div=434, send 0x00, 0xFF, 0x3C back-to-back with zero idle -> three rx_wr pulses in order, data 0x00/0xFF/0x3C, busy low only briefly between frames.
3. baud_div=2604, RX low for 500 cycles then high -> no rx_wr/frame_err, busy returns 0 by T0+1303.
4. Send 0x3C with stop bit held low for 3 bit times -> one frame_err pulse, no rx_wr, rx_data unchanged. A later valid 0x5A yields rx_wr with 0x5A.
5. q_full=1, send 0x81 -> overrun pulse, rx_wr=0, rx_data=0x81. Deassert q_full and send 0x7E -> normal rx_wr.
6. Assert rst during data bit 4 of a frame, release; change baud_div 2604->434 mid-frame of the next frame -> aborted frame produces nothing; the in-flight frame still decodes correctly at 2604; the following frame decodes at 434.
